lsu_dm_master: RTL and testbench

- Load/store unit on the CPU side of the word-wide data memory. It accepts byte, halfword and word load/store requests from the MEM stage and drives the memory port: write enable, word address, write data and combinational read data.
- It performs sign/zero extension on loads and detects misaligned accesses.
- The memory only supports whole-word writes, so sub-word stores are done as a read-modify-write.
- It stalls the pipeline through req_ready while a read-modify-write is in progress.

---
 rtl/lsu_dm_if.sv | 27 ++
 rtl/lsu_dm_master.sv | 70 +++++++
 tb/tb_lsu_dm_master.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_dm_if.sv
// lsu_dm_if: request/response and data-memory port bundle for the load/store unit
interface lsu_dm_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_we;
  logic [2:0]    req_type;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport master (
    input  req_valid, req_we, req_type, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output req_valid, req_we, req_type, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_dm_master.sv
// lsu_dm_master: byte/half/word load-store unit with read-modify-write sub-word stores
module lsu_dm_master #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input logic       clk,
  input logic       rstn,
  lsu_dm_if.master  bus
);
  typedef enum logic {IDLE, RMW_WR} state_t;
  state_t        state, state_n;
  logic [1:0]    a;
  logic [2:0]    t;
  logic [4:0]    sh;
  logic          illegal, mis, err, acc, sub_st, wd_st;
  logic [DW-1:0] shifted, ld, mask, merged, rdata_n, rmw_data;
  logic [AW-1:0] waddr, rmw_addr;
  assign a       = bus.req_addr[1:0];
  assign t       = bus.req_type;
  assign sh      = {a, 3'b000};
  // stores have no unsigned variants, so BU/HU codes are only legal for loads
  assign illegal = bus.req_we ? !(t inside {3'b000, 3'b001, 3'b010})
                              : !(t inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign mis     = (t[1:0] == 2'b01 && a[0]) || (t == 3'b010 && a != 2'b00);
  assign err     = illegal || mis;
  assign acc     = bus.req_valid && state == IDLE;
  assign sub_st  = acc && bus.req_we && !err && t != 3'b010;
  assign wd_st   = acc && bus.req_we && !err && t == 3'b010;
  assign waddr   = {bus.req_addr[AW-1:2], 2'b00};
  assign shifted = bus.mem_rdata >> sh;
  assign ld      = t == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]}
                 : t == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]}
                 : t == 3'b100 ? {24'b0, shifted[7:0]}
                 : t == 3'b101 ? {16'b0, shifted[15:0]}
                 : shifted;
  assign mask    = (t[0] ? 32'h0000_ffff : 32'h0000_00ff) << sh;
  assign merged  = (bus.mem_rdata & ~mask) | ((bus.req_wdata << sh) & mask);
  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end
  // next state, handshake and memory port; write enable is cut as soon as reset asserts
  always_comb begin
    state_n       = state == IDLE && sub_st ? RMW_WR : IDLE;
    bus.req_ready = state == IDLE;
    bus.mem_we    = rstn && (state == RMW_WR || wd_st);
    bus.mem_addr  = state == RMW_WR ? rmw_addr : waddr;
    bus.mem_wdata = state == RMW_WR ? rmw_data : bus.req_wdata;
    rdata_n       = acc && !bus.req_we && !err ? ld : '0;
  end
  // registered response and latched merge word for the write-back cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      rmw_addr       <= '0;
      rmw_data       <= '0;
    end else begin
      bus.resp_valid <= (acc && !sub_st) || state == RMW_WR;
      bus.resp_err   <= acc && err;
      bus.resp_rdata <= rdata_n;
      if (sub_st) begin
        rmw_addr <= waddr;
        rmw_data <= merged;
      end
    end
  end
endmodule

// File: tb/tb_lsu_dm_master.sv
// tb_lsu_dm_master: byte-level memory model with per-cycle response/write checking
module tb_lsu_dm_master;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  lsu_dm_if #(.DW(32), .AW(32)) bus();
  lsu_dm_master #(.DW(32), .AW(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {int due; logic [31:0] rdata; logic err;} resp_t;
  typedef struct {int due; int widx; logic [31:0] data; logic rmw;} wr_t;

  logic [31:0] dmem [16] = '{default: 32'h0};
  logic [7:0]  refm [64] = '{default: 8'h0};
  resp_t rq[$];
  wr_t   wq[$];
  resp_t rlog[$];
  int cyc = 0, nchk = 0, nfail = 0, we_cnt = 0;

  assign bus.mem_rdata = dmem[bus.mem_addr[5:2]];
  always @(posedge clk) if (bus.mem_we) dmem[bus.mem_addr[5:2]] <= bus.mem_wdata;
  always @(negedge clk) if (bus.mem_we) we_cnt++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rword(input int w);
    return {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]};
  endfunction

  always @(negedge clk) begin
    logic exp_ready, bad;
    logic [31:0] v;
    resp_t r;
    wr_t w;
    int sz, ia;
    cyc++;
    if (!rstn) begin
      rq.delete();
      wq.delete();
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_resp_rdata", bus.resp_rdata, 0);
      check("rst_resp_err", bus.resp_err, 0);
      check("rst_req_ready", bus.req_ready, 1);
    end else begin
      if (bus.resp_valid) rlog.push_back('{cyc, bus.resp_rdata, bus.resp_err});
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        check("resp_valid", bus.resp_valid, 1);
        check("resp_rdata", bus.resp_rdata, r.rdata);
        check("resp_err", bus.resp_err, {31'b0, r.err});
      end else check("resp_valid_idle", bus.resp_valid, 0);
      exp_ready = !(wq.size() > 0 && wq[0].rmw && wq[0].due == cyc);
      check("req_ready", bus.req_ready, {31'b0, exp_ready});
      if (bus.req_valid && exp_ready) begin
        sz  = bus.req_type[1:0] == 2'd0 ? 1 : bus.req_type[1:0] == 2'd1 ? 2 : 4;
        ia  = int'(bus.req_addr[5:0]);
        bad = bus.req_we ? !(bus.req_type inside {3'd0, 3'd1, 3'd2})
                         : !(bus.req_type inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        bad = bad || (ia % sz != 0);
        if (bad) rq.push_back('{cyc + 1, 32'h0, 1'b1});
        else if (!bus.req_we) begin
          v = 0;
          for (int k = 0; k < sz; k++) v = v | (32'(refm[ia + k]) << (8 * k));
          if (!bus.req_type[2] && sz < 4 && v[8*sz-1]) v = v | (32'hffff_ffff << (8 * sz));
          rq.push_back('{cyc + 1, v, 1'b0});
        end else begin
          v = rword(ia / 4);
          for (int k = 0; k < sz; k++) v[8*(ia%4+k) +: 8] = bus.req_wdata[8*k +: 8];
          wq.push_back('{sz == 4 ? cyc : cyc + 1, ia / 4, v, sz != 4});
          rq.push_back('{sz == 4 ? cyc + 1 : cyc + 2, 32'h0, 1'b0});
        end
      end
      if (wq.size() > 0 && wq[0].due == cyc) begin
        w = wq.pop_front();
        check("mem_we", bus.mem_we, 1);
        check("mem_addr", bus.mem_addr, 32'(w.widx * 4));
        check("mem_wdata", bus.mem_wdata, w.data);
        for (int k = 0; k < 4; k++) refm[4*w.widx+k] = w.data[8*k +: 8];
      end else check("mem_we_idle", bus.mem_we, 0);
    end
  end

  task automatic issue(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_type  = t;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (1) begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
      if (n > 8) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input int i, input logic [31:0] d, input logic e);
    if (i >= rlog.size()) check({nm, "_missing"}, 32'(rlog.size()), 32'(i + 1));
    else begin
      check(nm, rlog[i].rdata, d);
      check({nm, "_err"}, {31'b0, rlog[i].err}, {31'b0, e});
    end
  endtask

  initial begin
    int w0, n0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_type  = 3'd0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    idle(2);
    rstn = 1'b1;
    issue(1'b1, 3'd2, 32'h10, 32'h8899aabb);
    issue(1'b0, 3'd0, 32'h11, 32'h0);
    issue(1'b0, 3'd4, 32'h11, 32'h0);
    issue(1'b0, 3'd1, 32'h12, 32'h0);
    issue(1'b0, 3'd5, 32'h12, 32'h0);
    idle(3);
    check("preload_word", dmem[4], 32'h8899aabb);
    lit("lb", 1, 32'hffffffaa, 1'b0);
    lit("lbu", 2, 32'h000000aa, 1'b0);
    lit("lh", 3, 32'hffff8899, 1'b0);
    lit("lhu", 4, 32'h00008899, 1'b0);
    if (rlog.size() > 4) check("load_streak", 32'(rlog[4].due - rlog[1].due), 3);
    w0 = we_cnt;
    issue(1'b1, 3'd0, 32'h13, 32'h12345655);
    idle(3);
    check("sb_word", dmem[4], 32'h5599aabb);
    check("sb_we_pulses", 32'(we_cnt - w0), 1);
    issue(1'b1, 3'd1, 32'h10, 32'h0000cafe);
    idle(3);
    check("sh_word", dmem[4], 32'h5599cafe);
    issue(1'b1, 3'd2, 32'h14, 32'hdeadbeef);
    issue(1'b0, 3'd2, 32'h14, 32'h0);
    issue(1'b0, 3'd2, 32'h10, 32'h0);
    idle(3);
    lit("sw_resp", 7, 32'h0, 1'b0);
    lit("lw14", 8, 32'hdeadbeef, 1'b0);
    lit("lw10", 9, 32'h5599cafe, 1'b0);
    if (rlog.size() > 8) check("lw_after_sw", 32'(rlog[8].due - rlog[7].due), 1);
    w0 = we_cnt;
    issue(1'b0, 3'd2, 32'h12, 32'h0);
    issue(1'b1, 3'd1, 32'h11, 32'h0000ffff);
    issue(1'b0, 3'd3, 32'h10, 32'h0);
    idle(3);
    lit("err_lw", 10, 32'h0, 1'b1);
    lit("err_sh", 11, 32'h0, 1'b1);
    lit("err_type", 12, 32'h0, 1'b1);
    check("err_no_we", 32'(we_cnt - w0), 0);
    check("err_word10", dmem[4], 32'h5599cafe);
    check("err_word14", dmem[5], 32'hdeadbeef);
    n0 = rlog.size();
    w0 = we_cnt;
    issue(1'b1, 3'd0, 32'h10, 32'h00000077);
    rstn = 1'b0;
    #1 check("rmw_rst_we", bus.mem_we, 0);
    idle(2);
    rstn = 1'b1;
    idle(3);
    check("rmw_rst_word", dmem[4], 32'h5599cafe);
    check("rmw_rst_no_we", 32'(we_cnt - w0), 0);
    check("rmw_rst_no_resp", 32'(rlog.size()), 32'(n0));
    check("post_rst_ready", bus.req_ready, 1);
    check("post_rst_valid", bus.resp_valid, 0);
    check("post_rst_rdata", bus.resp_rdata, 0);
    for (int i = 0; i < 16; i++) check($sformatf("mem_word%0d", i), dmem[i], rword(i));
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
